// File: rtl/fetch_prefetch.sv
// Pipelined instruction fetch stage with a DEPTH-entry prefetch queue ahead of the decoder.
// Define FETCH_SEQ_BURST_EN to mark back-to-back sequential fetches as SEQ transfers.
module fetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        bus_available,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [1:0]  bus_trans,
  input  logic        bus_response,
  input  logic [31:0] bus_read_data,
  output logic        decoder_valid,
  input  logic        decoder_ready,
  output logic [31:0] decoder_data,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]      fetch_pc;
  logic             halted;
  logic             data_active;
  logic [31:0]      data_addr;
  logic [1:0]       drop_cnt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [31:0]      q_data [DEPTH];
  logic [31:0]      q_pc [DEPTH];
  logic [DEPTH-1:0] q_fault;

  logic          addr_active;
  logic          completing;
  logic          dropping;
  logic          err_now;
  logic          push;
  logic          pop;
  logic          issue;
  logic [1:0]    in_flight;
  logic [1:0]    remaining;
  logic [PW+1:0] credit_used;
  logic [1:0]    issue_trans;

  // Queued entries plus transfers still on the bus form the credit that bounds issue.
  always_comb begin
    addr_active = bus_trans != TRANS_IDLE;
    in_flight   = {1'b0, addr_active} + {1'b0, data_active};
    completing  = bus_ready && data_active;
    dropping    = completing && (drop_cnt != 2'd0);
    err_now     = completing && !dropping && bus_response;
    push        = completing && !dropping && !redirect;
    pop         = decoder_valid && decoder_ready && !redirect;
    remaining   = bus_ready ? {1'b0, addr_active} : in_flight;
    credit_used = {1'b0, count} + {{PW{1'b0}}, in_flight};
    issue       = bus_available && bus_ready && !halted && !redirect && !err_now &&
                  (credit_used < (PW+2)'(DEPTH));
  end

`ifdef FETCH_SEQ_BURST_EN
  logic        seq_ok;
  logic [31:0] last_issue;

  // A burst continues only across unbroken back-to-back issues within one 1 KiB page.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq_ok     <= 1'b0;
      last_issue <= 32'h0;
    end else if (redirect || err_now) begin
      seq_ok <= 1'b0;
    end else if (issue) begin
      seq_ok     <= 1'b1;
      last_issue <= fetch_pc;
    end else if (bus_ready) begin
      seq_ok <= 1'b0;
    end
  end

  assign issue_trans = (seq_ok && (fetch_pc == last_issue + 32'd4) && (fetch_pc[9:0] != 10'd0))
                       ? TRANS_SEQ : TRANS_NONSEQ;
`else
  assign issue_trans = TRANS_NONSEQ;
`endif

  assign bus_write = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_trans   <= TRANS_IDLE;
      bus_address <= RESET_PC;
      fetch_pc    <= RESET_PC;
      data_active <= 1'b0;
      data_addr   <= 32'h0;
    end else begin
      if (bus_ready) begin
        data_active <= addr_active;
        data_addr   <= bus_address;
        bus_trans   <= issue ? issue_trans : TRANS_IDLE;
      end
      if (issue) begin
        bus_address <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'd3;
      end
    end
  end

  // Transfers still outstanding at a redirect or behind an error are discarded on completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted   <= 1'b0;
      drop_cnt <= 2'd0;
    end else if (redirect) begin
      halted   <= 1'b0;
      drop_cnt <= remaining;
    end else begin
      if (err_now) begin
        halted   <= 1'b1;
        drop_cnt <= remaining;
      end else if (dropping) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wr_ptr]  <= bus_response ? 32'h0 : bus_read_data;
      q_pc[wr_ptr]    <= data_addr;
      q_fault[wr_ptr] <= bus_response;
    end
  end

  assign decoder_valid = count != '0;
  assign decoder_data  = decoder_valid ? q_data[rd_ptr]  : 32'h0;
  assign out_pc        = decoder_valid ? q_pc[rd_ptr]    : 32'h0;
  assign out_fault     = decoder_valid ? q_fault[rd_ptr] : 1'b0;

endmodule
